line_fill_ctrl: RTL and testbench
=================================

LINE_FILL_CTRL -- requirements
Module: line_fill_ctrl

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYC, default 1023, giving the maximum number of cycles to wait for one bus ack.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port mem_req_in, input, 1 bit: line-fill request from the icache controller (single-cycle pulse).
REQ-005 The block SHALL have port mem_addr_in, input, 32 bits: line address; bits [4:0] are ignored.
REQ-006 The block SHALL have port mem_data_out, output, 256 bits: assembled line; word k is at bits [32k+31:32k].
REQ-007 The block SHALL have port mem_ready_out, output, 1 bit: single-cycle pulse meaning the line is complete.
REQ-008 The block SHALL have port bus_req_out, output, 1 bit: word-bus read request.
REQ-009 The block SHALL have port bus_addr_out, output, 32 bits: word-bus byte address, word-aligned.
REQ-010 The block SHALL have port bus_rdata_in, input, 32 bits: word-bus read data, valid when bus_ack_in=1.
REQ-011 The block SHALL have port bus_ack_in, input, 1 bit: word-bus beat acknowledge.
REQ-012 The block SHALL have port err_out, output, 1 bit: sticky timeout error flag.

Function
REQ-013 The block SHALL implement the states IDLE, FETCH, DONE and ERR.
REQ-014 In IDLE, a mem_req_in=1 SHALL latch {mem_addr_in[31:5],5'b0} as the line base, clear the beat counter (3 bits) and the timeout counter, and move to FETCH.
REQ-015 mem_req_in SHALL be ignored in FETCH, DONE and ERR.
REQ-016 In FETCH, the block SHALL hold bus_req_out=1 continuously, with bus_addr_out={base[31:5],beat,2'b00}.
REQ-017 In FETCH, a cycle with bus_ack_in=1 SHALL write bus_rdata_in into mem_data_out word[beat], increment beat, and clear the timeout counter.
REQ-018 bus_addr_out SHALL advance to the next word on the cycle after each ack.
REQ-019 An ack on beat 7 SHALL move the block to DONE; the beat counter wrapping to 0 is not otherwise observable.
REQ-020 bus_ack_in SHALL be ignored when bus_req_out=0.
REQ-021 DONE SHALL last exactly one cycle, with mem_ready_out=1 and bus_req_out=0, then return to IDLE.
REQ-022 mem_data_out SHALL hold the completed line unchanged from DONE until the first ack of the next fill, so that a consumer sampling one or more cycles after mem_ready_out reads the correct line.
REQ-023 Minimum latency, with ack every cycle: mem_req_in at cycle 0 -> bus beats in cycles 1..8 -> mem_ready_out in cycle 9.
REQ-024 In FETCH, the timeout counter SHALL increment on each cycle without an ack.
REQ-025 If the timeout counter reaches TIMEOUT_CYC without an ack, the block SHALL go to ERR.
REQ-026 ERR SHALL be terminal until reset, with err_out=1, bus_req_out=0 and mem_ready_out never asserted.
REQ-027 The timeout counter SHALL be wide enough for TIMEOUT_CYC and SHALL saturate, never wrap.
REQ-028 An ack in the same cycle that the timeout limit is reached SHALL win: the beat is accepted and no error is raised.
REQ-029 All outputs SHALL be driven from registered state; there SHALL be no combinational path from bus_ack_in or mem_req_in to any output.

Reset
REQ-030 When rst=1 at a clock edge, state SHALL become IDLE, regardless of current state (mid-fill included).
REQ-031 When rst=1 at a clock edge, the beat and timeout counters SHALL clear to 0.
REQ-032 When rst=1 at a clock edge, mem_data_out SHALL become 256'd0 and bus_addr_out SHALL become 32'd0.
REQ-033 When rst=1 at a clock edge, bus_req_out, mem_ready_out and err_out SHALL become 0.
REQ-034 A mem_req_in in the same cycle as rst=1 SHALL be dropped.

Verification
REQ-035 Ack every cycle, mem_addr_in=0x0000_1234, bus_rdata_in=0xA0+beat -> the bench SHALL observe bus_addr_out 0x1220,0x1224..0x123C, mem_ready_out in cycle 9, and mem_data_out word k=0xA0+k.
REQ-036 Ack with 3 wait cycles per beat -> the bench SHALL observe each bus_addr_out held 4 cycles, mem_ready_out at cycle 33, and the data held for 5 cycles after ready with no new request.
REQ-037 mem_req_in pulsed during FETCH with a different address -> the bench SHALL observe it ignored: address sequence unchanged, a single mem_ready_out.
REQ-038 TIMEOUT_CYC=8, no ack on beat 2 -> the bench SHALL observe ERR entered after 8 idle cycles, err_out=1 sticky, bus_req_out=0, and later requests ignored until rst.
REQ-039 rst asserted for 1 cycle after beat 4 is acked -> the bench SHALL observe all outputs 0 on the next cycle; a new request then fetches all 8 beats from word 0.
REQ-040 Back-to-back fills (mem_req_in the cycle after DONE) -> the bench SHALL observe the second line base used and the first line's data intact until the second fill's first ack.

Source files
------------

// File: rtl/line_fill_ctrl.sv
// line_fill_ctrl: assembles a 256-bit cache line from eight word-bus reads, with a per-beat ack timeout
module line_fill_ctrl #(
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         mem_req_in,
  input  logic [31:0]  mem_addr_in,
  output logic [255:0] mem_data_out,
  output logic         mem_ready_out,
  output logic         bus_req_out,
  output logic [31:0]  bus_addr_out,
  input  logic [31:0]  bus_rdata_in,
  input  logic         bus_ack_in,
  output logic         err_out
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  typedef enum logic [1:0] {IDLE, FETCH, DONE, ERR} state_t;
  state_t        state, state_nx;
  logic [26:0]   base;
  logic [2:0]    beat;
  logic [TW-1:0] tcnt;
  logic          start, ack, tmo;
  assign start = state == IDLE && mem_req_in;
  assign ack   = state == FETCH && bus_ack_in;
  // an ack on the limit cycle takes priority over the timeout
  assign tmo   = state == FETCH && !bus_ack_in && tcnt == TW'(TIMEOUT_CYC - 1);
  always_comb begin
    state_nx = state;
    state_nx = start                  ? FETCH :
               ack && beat == 3'd7    ? DONE  :
               tmo                    ? ERR   :
               state == DONE          ? IDLE  : state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      base         <= '0;
      beat         <= '0;
      tcnt         <= '0;
      mem_data_out <= '0;
    end else begin
      state <= state_nx;
      if (start) begin
        base <= mem_addr_in[31:5];
        beat <= '0;
        tcnt <= '0;
      end
      if (ack) begin
        mem_data_out[{beat, 5'd0} +: 32] <= bus_rdata_in;
        beat <= beat + 3'd1;
        tcnt <= '0;
      end else if (state == FETCH && tcnt != TW'(TIMEOUT_CYC)) begin
        tcnt <= tcnt + TW'(1);
      end
    end
  end
  assign bus_req_out   = state == FETCH;
  assign mem_ready_out = state == DONE;
  assign err_out       = state == ERR;
  assign bus_addr_out  = {base, beat, 2'b00};
endmodule

// File: tb/tb_line_fill_ctrl.sv
// tb_line_fill_ctrl: scoreboard bench; stimulus queues expected bus addresses and lines, a monitor checks them
module tb_line_fill_ctrl;
  logic         clk = 0;
  logic         rst = 1;
  logic         mem_req_in = 0;
  logic [31:0]  mem_addr_in = 0;
  logic [255:0] mem_data_out;
  logic         mem_ready_out;
  logic         bus_req_out;
  logic [31:0]  bus_addr_out;
  logic [31:0]  bus_rdata_in = 0;
  logic         bus_ack_in = 0;
  logic         err_out;

  typedef struct {
    logic [255:0] d;
    int           c;
  } line_t;

  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          waits = 0;
  logic [3:0]  stall_beat = 4'd15;
  logic [31:0] dpat = 0;
  logic [31:0] exp_addr[$];
  line_t       exp_line[$];

  line_fill_ctrl #(.TIMEOUT_CYC(8)) dut (
    .clk(clk), .rst(rst), .mem_req_in(mem_req_in), .mem_addr_in(mem_addr_in),
    .mem_data_out(mem_data_out), .mem_ready_out(mem_ready_out), .bus_req_out(bus_req_out),
    .bus_addr_out(bus_addr_out), .bus_rdata_in(bus_rdata_in), .bus_ack_in(bus_ack_in),
    .err_out(err_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [255:0] mk_line(input logic [31:0] dp);
    logic [255:0] l;
    for (int k = 0; k < 8; k++) l[32*k +: 32] = dp + 32'(k);
    return l;
  endfunction

  task automatic chk(input string n, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, got, exp);
    end
  endtask

  task automatic do_req(input logic [31:0] a, input logic [31:0] dp, input bit push_line, output int c);
    line_t e;
    @(negedge clk);
    c = cyc;
    dpat = dp;
    mem_addr_in = a;
    mem_req_in = 1;
    for (int k = 0; k < 8; k++) exp_addr.push_back({a[31:5], 5'd0} + 32'(4 * k));
    if (push_line) begin
      e.d = mk_line(dp);
      e.c = c + 8 * (waits + 1) + 1;
      exp_line.push_back(e);
    end
    @(negedge clk);
    mem_req_in = 0;
  endtask

  task automatic pulse(input logic [31:0] a);
    @(negedge clk);
    mem_addr_in = a;
    mem_req_in = 1;
    @(negedge clk);
    mem_req_in = 0;
  endtask

  task automatic wait_ready(input int bound);
    int n = 0;
    while (!mem_ready_out && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (!mem_ready_out) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: no mem_ready_out within %0d cycles", bound);
    end
  endtask

  task automatic chk_zero(input string n);
    chk({n, "_data"}, mem_data_out, '0);
    chk({n, "_addr"}, 256'(bus_addr_out), '0);
    chk({n, "_req"}, 256'(bus_req_out), '0);
    chk({n, "_ready"}, 256'(mem_ready_out), '0);
    chk({n, "_err"}, 256'(err_out), '0);
  endtask

  // bus slave: acks after `waits` idle cycles, never acks the stalled beat
  initial begin
    int w = 0;
    forever begin
      @(negedge clk);
      #1;
      bus_rdata_in = dpat + 32'(bus_addr_out[4:2]);
      if (rst || !bus_req_out) begin
        bus_ack_in = 0;
        w = 0;
      end else if (w >= waits && {1'b0, bus_addr_out[4:2]} != stall_beat) begin
        bus_ack_in = 1;
        w = 0;
      end else begin
        bus_ack_in = 0;
        w++;
      end
    end
  end

  initial begin
    line_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst) begin
        if (bus_req_out) begin
          if (exp_addr.size() == 0) chk("bus_addr_unexpected", 256'(bus_addr_out), 256'(32'hFFFF_FFFF));
          else begin
            chk("bus_addr", 256'(bus_addr_out), 256'(exp_addr[0]));
            if (bus_ack_in) void'(exp_addr.pop_front());
          end
        end
        if (mem_ready_out) begin
          if (exp_line.size() == 0) chk("ready_unexpected", 256'(mem_ready_out), '0);
          else begin
            e = exp_line.pop_front();
            chk("line_data", mem_data_out, e.d);
            chk("ready_cycle", 256'(cyc), 256'(e.c));
          end
        end
      end
    end
  end

  initial begin
    int c;
    mem_req_in = 1;
    mem_addr_in = 32'h9999_9999;
    repeat (3) @(negedge clk);
    rst = 0;
    mem_req_in = 0;
    chk_zero("reset");
    @(negedge clk);
    chk("req_during_rst_dropped", 256'(bus_req_out), '0);

    do_req(32'h0000_1234, 32'hA0, 1, c);
    wait_ready(20);

    waits = 3;
    do_req(32'h0000_8000, 32'h100, 1, c);
    wait_ready(50);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_data", mem_data_out, mk_line(32'h100));
      chk("hold_idle", 256'(bus_req_out | mem_ready_out), '0);
    end

    waits = 0;
    do_req(32'h0000_2000, 32'h200, 1, c);
    @(negedge clk);
    pulse(32'hFFFF_FFE0);
    wait_ready(20);

    do_req(32'h0000_3000, 32'h300, 1, c);
    wait_ready(20);
    do_req(32'h0000_4000, 32'h400, 1, c);
    chk("b2b_hold", mem_data_out, mk_line(32'h300));
    chk("b2b_base", 256'(bus_addr_out), 256'(32'h4000));
    wait_ready(20);

    do_req(32'h0000_5000, 32'h500, 0, c);
    repeat (5) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    exp_addr.delete();
    chk_zero("midfill_rst");
    do_req(32'h0000_5000, 32'h600, 1, c);
    wait_ready(20);

    waits = 7;
    do_req(32'h0000_6000, 32'h650, 1, c);
    wait_ready(80);
    chk("ack_on_limit_no_err", 256'(err_out), '0);

    waits = 0;
    stall_beat = 4'd2;
    do_req(32'h0000_7000, 32'h700, 0, c);
    while (cyc < c + 10) @(negedge clk);
    chk("tmo_last_req", 256'(bus_req_out), 256'(1));
    chk("tmo_last_err", 256'(err_out), '0);
    @(negedge clk);
    chk("tmo_err", 256'(err_out), 256'(1));
    chk("tmo_req_off", 256'(bus_req_out), '0);
    exp_addr.delete();
    pulse(32'h0000_8000);
    repeat (10) @(negedge clk);
    chk("err_sticky", 256'(err_out), 256'(1));
    chk("err_req_ignored", 256'(bus_req_out), '0);
    stall_beat = 4'd15;
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("err_cleared", 256'(err_out), '0);

    repeat (3) @(negedge clk);
    chk("addr_queue_empty", 256'(exp_addr.size()), '0);
    chk("line_queue_empty", 256'(exp_line.size()), '0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
